// File: rtl/matmul_drain_unit.sv
// rtl/matmul_drain_unit.sv - drains a finished 4x4 systolic result to the register file in two 8-thread beats
// Optional build macro: DRAIN_SATURATE_EN (signed saturation of accumulators instead of truncation).
module matmul_drain_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               matmul_done,
    input  logic                               pause,
    input  logic [15:0][ACC_WIDTH-1:0]         acc_in,
    input  logic                               wb_ready,
    output logic                               wb_valid,
    output logic                               wb_beat,
    output logic [7:0][DATA_WIDTH-1:0]         wb_data,
    output logic                               busy,
    output logic                               array_clear,
    output logic                               drain_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE0 = 2'd1,
        WRITE1 = 2'd2,
        DONE   = 2'd3
    } state_t;

`ifdef DRAIN_SATURATE_EN
    // Largest / smallest accumulator values that still fit in one writeback element.
    localparam logic [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

    state_t                      state_q, state_d;
    logic                        armed_q, armed_d;
    logic [15:0][DATA_WIDTH-1:0] snap_q, snap_d;
    logic                        capture;

    // Narrow one accumulator to an element: clamp when saturation is built in, otherwise keep the low bits.
    function automatic logic [DATA_WIDTH-1:0] to_elem(input logic [ACC_WIDTH-1:0] a);
`ifdef DRAIN_SATURATE_EN
        if ($signed(a) > $signed(SAT_MAX)) begin
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if ($signed(a) < $signed(SAT_MIN)) begin
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            return a[DATA_WIDTH-1:0];
        end
`else
        return DATA_WIDTH'(a);
`endif
    endfunction

    // State, arm flag and snapshot registers; reset leaves the unit idle and armed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            armed_q <= 1'b1;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            snap_q  <= snap_d;
        end
    end

    // Next-state and handshake outputs; pause freezes everything except the one-cycle DONE pulse.
    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        snap_d      = snap_q;
        capture     = 1'b0;
        wb_valid    = 1'b0;
        wb_beat     = 1'b0;
        busy        = (state_q != IDLE);
        array_clear = 1'b0;
        drain_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (matmul_done && armed_q && !pause) begin
                    capture = 1'b1;
                    state_d = WRITE0;
                end
            end
            WRITE0: begin
                wb_valid = !pause;
                if (!pause && wb_ready) begin
                    state_d = WRITE1;
                end
            end
            WRITE1: begin
                wb_beat  = 1'b1;
                wb_valid = !pause;
                if (!pause && wb_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                array_clear = 1'b1;
                drain_done  = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A low matmul_done re-arms; capturing consumes the arm so a held level drains only once.
        if (!pause) begin
            if (capture) begin
                armed_d = 1'b0;
            end else if (!matmul_done) begin
                armed_d = 1'b1;
            end
        end

        if (capture) begin
            for (int i = 0; i < 16; i++) begin
                snap_d[i] = to_elem(acc_in[i]);
            end
        end
    end

    // Beat data always comes from the snapshot: rows 0/1 except while in WRITE1, where rows 2/3 go out.
    always_comb begin
        wb_data = '0;
        for (int t = 0; t < 8; t++) begin
            wb_data[t] = (state_q == WRITE1) ? snap_q[8+t] : snap_q[t];
        end
    end

endmodule

// File: tb/tb_matmul_drain_unit.sv
// tb/tb_matmul_drain_unit.sv - scoreboard bench for matmul_drain_unit
module tb_matmul_drain_unit;

    localparam int DW = 16;
    localparam int AW = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 matmul_done;
    logic                 pause;
    logic [15:0][AW-1:0]  acc_in;
    logic                 wb_ready;
    logic                 wb_valid;
    logic                 wb_beat;
    logic [7:0][DW-1:0]   wb_data;
    logic                 busy;
    logic                 array_clear;
    logic                 drain_done;

    typedef struct {
        logic               beat;
        logic [7:0][DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   passed = 0;
    int   dd_cnt = 0;
    int   ac_cnt = 0;

    matmul_drain_unit #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .matmul_done (matmul_done),
        .pause       (pause),
        .acc_in      (acc_in),
        .wb_ready    (wb_ready),
        .wb_valid    (wb_valid),
        .wb_beat     (wb_beat),
        .wb_data     (wb_data),
        .busy        (busy),
        .array_clear (array_clear),
        .drain_done  (drain_done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] model_conv(input logic signed [AW-1:0] a);
`ifdef DRAIN_SATURATE_EN
        if (a > 32'sd32767) return 16'h7FFF;
        if (a < -32'sd32768) return 16'h8000;
        return a[15:0];
`else
        return a[15:0];
`endif
    endfunction

    task automatic push_drain(input logic [15:0][AW-1:0] acc);
        exp_t e;
        e.beat = 1'b0;
        for (int t = 0; t < 8; t++) e.data[t] = model_conv(acc[t]);
        sb.push_back(e);
        e.beat = 1'b1;
        for (int t = 0; t < 8; t++) e.data[t] = model_conv(acc[8+t]);
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted beat is popped and compared against the model.
    always @(negedge clk) begin
        if (!reset) begin
            if (wb_valid && wb_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_unexpected_beat: got beat %0d data %h, required no beat", wb_beat, wb_data);
                end else begin
                    mon_e = sb.pop_front();
                    if (wb_beat !== mon_e.beat || wb_data !== mon_e.data)
                        $display("FAIL sb_beat: got beat %0d data %h, required beat %0d data %h",
                                 wb_beat, wb_data, mon_e.beat, mon_e.data);
                    else passed++;
                end
            end
            if (drain_done) dd_cnt++;
            if (array_clear) ac_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        reset = 1'b1; matmul_done = 1'b0; pause = 1'b0; wb_ready = 1'b0; acc_in = '0;
        #12;
        checks++;
        if ({busy, wb_valid, wb_beat, array_clear, drain_done} !== 5'b0)
            $display("FAIL reset_ctrl: got %b, required 00000", {busy, wb_valid, wb_beat, array_clear, drain_done});
        else passed++;
        checks++;
        if (wb_data !== '0) $display("FAIL reset_data: got %h, required 0", wb_data);
        else passed++;
        step();
        reset = 1'b0;
        step(); step();
        checks++;
        if (busy !== 1'b0) $display("FAIL idle_busy: got %b, required 0", busy);
        else passed++;
    endtask

    task automatic test_basic();
        logic [15:0][AW-1:0] acc;
        int d0, a0;
        for (int i = 0; i < 16; i++) acc[i] = 32'(i);
        acc_in = acc; push_drain(acc);
        d0 = dd_cnt; a0 = ac_cnt;
        wb_ready = 1'b1; matmul_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 16; i++) acc_in[i] = 32'hDEAD0000 + 32'(i);
        checks++;
        if (!(busy === 1'b1 && wb_valid === 1'b1 && wb_beat === 1'b0))
            $display("FAIL basic_write0: got busy %b valid %b beat %b, required 1 1 0", busy, wb_valid, wb_beat);
        else passed++;
        @(negedge clk);
        checks++;
        if (!(wb_valid === 1'b1 && wb_beat === 1'b1))
            $display("FAIL basic_write1: got valid %b beat %b, required 1 1", wb_valid, wb_beat);
        else passed++;
        @(negedge clk);
        checks++;
        if (!(drain_done === 1'b1 && array_clear === 1'b1 && wb_valid === 1'b0))
            $display("FAIL basic_done: got done %b clear %b valid %b, required 1 1 0", drain_done, array_clear, wb_valid);
        else passed++;
        @(negedge clk);
        checks++;
        if (!(busy === 1'b0 && drain_done === 1'b0))
            $display("FAIL basic_back_idle: got busy %b done %b, required 0 0", busy, drain_done);
        else passed++;
        checks++;
        if (dd_cnt - d0 != 1 || ac_cnt - a0 != 1)
            $display("FAIL basic_pulses: got done %0d clear %0d, required 1 1", dd_cnt - d0, ac_cnt - a0);
        else passed++;
        step(); matmul_done = 1'b0; step(); step();
    endtask

    task automatic test_backpressure();
        logic [15:0][AW-1:0] acc;
        logic [7:0][DW-1:0]  exp0;
        int n;
        for (int i = 0; i < 16; i++) acc[i] = 32'($urandom_range(0, 65535));
        acc_in = acc; push_drain(acc);
        for (int t = 0; t < 8; t++) exp0[t] = model_conv(acc[t]);
        wb_ready = 1'b0; matmul_done = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (!(wb_valid === 1'b1 && wb_beat === 1'b0 && wb_data === exp0))
                $display("FAIL bp_hold_%0d: got valid %b beat %b data %h, required 1 0 %h",
                         k, wb_valid, wb_beat, wb_data, exp0);
            else passed++;
        end
        @(posedge clk); #1;
        wb_ready = 1'b1;
        for (n = 5; n <= 24; n++) begin
            @(negedge clk);
            if (drain_done) break;
        end
        checks++;
        if (n != 7) $display("FAIL bp_latency: got done at cycle %0d, required 7", n);
        else passed++;
        step(); matmul_done = 1'b0; step(); step();
    endtask

    task automatic test_pause();
        logic [15:0][AW-1:0] acc;
        for (int i = 0; i < 16; i++) acc[i] = 32'(100 * i + 7);
        acc_in = acc; push_drain(acc);
        wb_ready = 1'b1; matmul_done = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        pause = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (!(wb_valid === 1'b0 && busy === 1'b1 && wb_beat === 1'b1 && drain_done === 1'b0))
                $display("FAIL pause_hold_%0d: got valid %b busy %b beat %b done %b, required 0 1 1 0",
                         k, wb_valid, busy, wb_beat, drain_done);
            else passed++;
        end
        @(posedge clk); #1;
        pause = 1'b0;
        @(negedge clk);
        checks++;
        if (!(wb_valid === 1'b1 && wb_beat === 1'b1))
            $display("FAIL pause_resume: got valid %b beat %b, required 1 1", wb_valid, wb_beat);
        else passed++;
        @(negedge clk);
        checks++;
        if (drain_done !== 1'b1) $display("FAIL pause_done: got %b, required 1", drain_done);
        else passed++;
        step(); matmul_done = 1'b0; step(); step();
    endtask

    task automatic test_rearm();
        logic [15:0][AW-1:0] acc;
        int d0;
        d0 = dd_cnt;
        for (int i = 0; i < 16; i++) acc[i] = 32'(1000 + i);
        acc_in = acc; push_drain(acc);
        wb_ready = 1'b1; matmul_done = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (dd_cnt - d0 != 1 || busy !== 1'b0)
            $display("FAIL rearm_single: got drains %0d busy %b, required 1 0", dd_cnt - d0, busy);
        else passed++;
        matmul_done = 1'b0;
        step();
        for (int i = 0; i < 16; i++) acc[i] = 32'(2000 + 3 * i);
        acc_in = acc; push_drain(acc);
        matmul_done = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (dd_cnt - d0 != 2) $display("FAIL rearm_second: got drains %0d, required 2", dd_cnt - d0);
        else passed++;
        checks++;
        if (sb.size() != 0) $display("FAIL rearm_sb_empty: got %0d pending, required 0", sb.size());
        else passed++;
        matmul_done = 1'b0; step(); step();
    endtask

    task automatic test_saturation();
        logic [15:0][AW-1:0] acc;
        logic [DW-1:0] e0, e1;
        int n;
`ifdef DRAIN_SATURATE_EN
        e0 = 16'h7FFF; e1 = 16'h8000;
`else
        e0 = 16'h9C40; e1 = 16'h63C0;
`endif
        acc = '0;
        acc[0] = 32'sd40000;  acc[1] = -32'sd40000;
        acc[2] = 32'sd32767;  acc[3] = -32'sd32768;
        acc[4] = 32'sd32768;  acc[5] = -32'sd32769;
        acc[8] = 32'sd100000; acc[9] = -32'sd5;
        acc_in = acc; push_drain(acc);
        wb_ready = 1'b1; matmul_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (wb_data[0] !== e0 || wb_data[1] !== e1)
            $display("FAIL sat_elems: got %h %h, required %h %h", wb_data[0], wb_data[1], e0, e1);
        else passed++;
        for (n = 2; n <= 20; n++) begin
            @(negedge clk);
            if (drain_done) break;
        end
        checks++;
        if (n != 3) $display("FAIL sat_latency: got done at cycle %0d, required 3", n);
        else passed++;
        step(); matmul_done = 1'b0; step(); step();
    endtask

    task automatic test_reset_mid();
        logic [15:0][AW-1:0] acc;
        int d0, a0, n;
        d0 = dd_cnt; a0 = ac_cnt;
        for (int i = 0; i < 16; i++) acc[i] = 32'(500 - 11 * i);
        acc_in = acc; push_drain(acc);
        wb_ready = 1'b1; matmul_done = 1'b1;
        @(posedge clk);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, wb_valid, wb_beat, array_clear, drain_done} !== 5'b0 || wb_data !== '0)
            $display("FAIL rmid_outputs: got %b data %h, required 00000 data 0",
                     {busy, wb_valid, wb_beat, array_clear, drain_done}, wb_data);
        else passed++;
        checks++;
        if (sb.size() != 1) $display("FAIL rmid_beat0_only: got %0d pending, required 1", sb.size());
        else passed++;
        sb.delete();
        matmul_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dd_cnt != d0 || ac_cnt != a0)
            $display("FAIL rmid_no_pulse: got done %0d clear %0d, required 0 0", dd_cnt - d0, ac_cnt - a0);
        else passed++;
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 16; i++) acc[i] = 32'(7 * i + 3);
        acc_in = acc; push_drain(acc);
        matmul_done = 1'b1;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (drain_done) break;
        end
        checks++;
        if (n != 4) $display("FAIL rmid_redrain: got done at cycle %0d, required 4", n);
        else passed++;
        step(); matmul_done = 1'b0; step();
        checks++;
        if (dd_cnt - d0 != 1) $display("FAIL rmid_count: got %0d drains, required 1", dd_cnt - d0);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_pause();
        test_rearm();
        test_saturation();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) $display("FAIL sb_drained: got %0d pending, required 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
